miriscv_lsu: RTL and testbench
==============================

MIRISCV_LSU -- requirements
Module: miriscv_lsu

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset; ports below, clock and reset first.
REQ-002 clk_i  in  1  system clock; all state updates on rising edge.
REQ-003 rstn_i  in  1  synchronous active-low reset, sampled on rising clk_i.
REQ-004 lsu_req_i  in  1  memory instruction in execute (decoder mem_req_o); held by core while lsu_stall_req_o=1.
REQ-005 lsu_we_i  in  1  1 = store, 0 = load (decoder mem_we_o).
REQ-006 lsu_size_i  in  3  000 byte, 001 half, 010 word, 100 byte unsigned, 101 half unsigned (decoder mem_size_o).
REQ-007 lsu_addr_i  in  32  byte address from ALU result.
REQ-008 lsu_data_i  in  32  store data (rs2).
REQ-009 lsu_data_o  out  32  extended load result to writeback.
REQ-010 lsu_stall_req_o  out  1  core stall request.
REQ-011 lsu_misaligned_o  out  1  misaligned-access pulse.
REQ-012 data_req_o  out  1  memory request, held until grant.
REQ-013 data_we_o  out  1  memory write enable.
REQ-014 data_be_o  out  4  byte enables.
REQ-015 data_addr_o  out  32  word address, bits [1:0] = 00.
REQ-016 data_wdata_o  out  32  lane-replicated store data.
REQ-017 data_gnt_i  in  1  memory accepted request.
REQ-018 data_rvalid_i  in  1  data_rdata_i valid.
REQ-019 data_rdata_i  in  32  memory read word.

Function
REQ-020 FSM states SHALL be IDLE, REQ, WAIT, DONE.
REQ-021 IDLE with lsu_req_i=1 SHALL register addr, we, size, be, wdata and go to REQ; else stay in IDLE.
REQ-022 REQ SHALL drive data_req_o=1 with registered address, we, be, wdata; gnt with we=1 goes to DONE; gnt with we=0 goes to WAIT; no gnt stays in REQ.
REQ-023 WAIT SHALL register extended data_rdata_i into lsu_data_o on data_rvalid_i and go to DONE.
REQ-024 DONE SHALL go to IDLE unconditionally.
REQ-025 lsu_stall_req_o SHALL be lsu_req_i AND (state != DONE), combinational.
REQ-026 Minimum stall: 2 cycles for a store and 3 cycles for a load with rvalid on the cycle after gnt.
REQ-027 data_gnt_i outside REQ and data_rvalid_i outside WAIT SHALL be ignored.
REQ-028 data_be_o: byte = 0001<<addr[1:0]; half = 0011<<{addr[1],0}; word = 1111.
REQ-029 data_wdata_o: byte = data[7:0] x4; half = data[15:0] x2; word = data unchanged.
REQ-030 Load extract: byte lane addr[1:0], half lane addr[1]; sign-extend if size[2]=0, zero-extend if size[2]=1.
REQ-031 Size codes 011, 110, 111 SHALL be treated as word.
REQ-032 lsu_data_o SHALL hold its value until the next completed load.
REQ-033 data_req_o SHALL be 0 in IDLE, WAIT and DONE.

Reset
REQ-034 rstn_i=0 in any state SHALL force IDLE and zero every output and register at the next edge.
REQ-035 After reset, a late data_rvalid_i SHALL be ignored and lsu_data_o SHALL remain 0.

Configuration
REQ-036 With LSU_MISALIGN_EXC_EN defined, a misaligned access (half with addr[0]=1, or word with addr[1:0]!=00) in IDLE SHALL go directly to DONE with no data_req_o, and SHALL pulse lsu_misaligned_o for the DONE cycle; lsu_data_o is unchanged.
REQ-037 Without LSU_MISALIGN_EXC_EN, lsu_misaligned_o SHALL be tied 0 and misaligned accesses SHALL proceed with the address rounded down to the access size.

Verification
REQ-038 Store word: addr=0x104, data=0xDEADBEEF, gnt on first REQ cycle -> data_addr_o=0x104, be=1111, wdata=0xDEADBEEF; stall high 2 cycles.
REQ-039 Load byte signed: addr=0x203, rdata=0x80xxxxxx -> lsu_data_o=0xFFFFFF80; with size=100 -> 0x00000080.
REQ-040 Store half: addr=0x12, data=0x0000ABCD -> be=1100, wdata=0xABCDABCD.
REQ-041 Grant delayed 3 cycles, rvalid 2 cycles after gnt -> data_req_o held 4 cycles, stall released only in DONE, stray rvalid in REQ ignored.
REQ-042 rstn_i low during WAIT, then rvalid=1 with rdata=0x12345678 -> IDLE, lsu_data_o=0, no stall.
REQ-043 Macro defined, load word addr=0x102 -> no data_req_o, lsu_misaligned_o=1 for 1 cycle; macro undefined -> data_addr_o=0x100, be=1111.

Source files
------------

// File: rtl/miriscv_lsu.sv
// Load/store unit: one outstanding access, a four-state FSM, byte lane steering and load extension.
// Optional macro LSU_MISALIGN_EXC_EN: flag misaligned accesses instead of rounding them down.
module miriscv_lsu (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [2:0]  lsu_size_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_data_i,
  output logic [31:0] lsu_data_o,
  output logic        lsu_stall_req_o,
  output logic        lsu_misaligned_o,
  output logic        data_req_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_gnt_i,
  input  logic        data_rvalid_i,
  input  logic [31:0] data_rdata_i
);

  // Memory handshake: data_req_o stays high with stable addr/we/be/wdata until a cycle
  // in which data_gnt_i is sampled high; data_rvalid_i is accepted only in ST_WAIT.
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_REQ = 2'd1, ST_WAIT = 2'd2, ST_DONE = 2'd3} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q;
  logic        we_q;
  logic [2:0]  size_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;

  logic        req_byte, req_half;
  logic [1:0]  req_off;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;

  always_comb begin
    req_byte = (lsu_size_i[1:0] == 2'b00);
    req_half = (lsu_size_i[1:0] == 2'b01);
    req_off  = 2'b00;
    be_d     = 4'b1111;
    wdata_d  = lsu_data_i;
    if (req_byte) begin
      req_off = lsu_addr_i[1:0];
      be_d    = 4'b0001 << req_off;
      wdata_d = {4{lsu_data_i[7:0]}};
    end else if (req_half) begin
      req_off = {lsu_addr_i[1], 1'b0};
      be_d    = 4'b0011 << req_off;
      wdata_d = {2{lsu_data_i[15:0]}};
    end
  end

`ifdef LSU_MISALIGN_EXC_EN
  logic req_misaligned;
  logic misalign_q;
  assign req_misaligned = (req_half && lsu_addr_i[0]) ||
                          (!req_byte && !req_half && (lsu_addr_i[1:0] != 2'b00));
`endif

  // Offset stored in addr_q[1:0] is already rounded to the access size.
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  always_comb begin
    case (addr_q[1:0])
      2'd0:    ld_byte = data_rdata_i[7:0];
      2'd1:    ld_byte = data_rdata_i[15:8];
      2'd2:    ld_byte = data_rdata_i[23:16];
      default: ld_byte = data_rdata_i[31:24];
    endcase
    ld_half = addr_q[1] ? data_rdata_i[31:16] : data_rdata_i[15:0];
    case (size_q[1:0])
      2'b00:   ld_ext = {{24{~size_q[2] & ld_byte[7]}}, ld_byte};
      2'b01:   ld_ext = {{16{~size_q[2] & ld_half[15]}}, ld_half};
      default: ld_ext = data_rdata_i;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (lsu_req_i) begin
`ifdef LSU_MISALIGN_EXC_EN
          state_d = req_misaligned ? ST_DONE : ST_REQ;
`else
          state_d = ST_REQ;
`endif
        end
      end
      ST_REQ:  if (data_gnt_i) state_d = we_q ? ST_DONE : ST_WAIT;
      ST_WAIT: if (data_rvalid_i) state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      size_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == ST_IDLE) && lsu_req_i) begin
        addr_q  <= {lsu_addr_i[31:2], req_off};
        we_q    <= lsu_we_i;
        size_q  <= lsu_size_i;
        be_q    <= be_d;
        wdata_q <= wdata_d;
      end
      if ((state_q == ST_WAIT) && data_rvalid_i) rdata_q <= ld_ext;
    end
  end

`ifdef LSU_MISALIGN_EXC_EN
  always_ff @(posedge clk_i) begin
    if (!rstn_i) misalign_q <= 1'b0;
    else         misalign_q <= (state_q == ST_IDLE) && lsu_req_i && req_misaligned;
  end
  assign lsu_misaligned_o = (state_q == ST_DONE) && misalign_q;
`else
  assign lsu_misaligned_o = 1'b0;
`endif

  assign lsu_data_o      = rdata_q;
  assign lsu_stall_req_o = lsu_req_i && (state_q != ST_DONE);
  assign data_req_o      = (state_q == ST_REQ);
  assign data_we_o       = we_q;
  assign data_be_o       = be_q;
  assign data_addr_o     = {addr_q[31:2], 2'b00};
  assign data_wdata_o    = wdata_q;

endmodule

// File: tb/tb_miriscv_lsu.sv
// Bench for miriscv_lsu: directed and random accesses against a small memory responder,
// with load results predicted into a queue and popped when the access completes.
module tb_miriscv_lsu;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic        lsu_req_i = 1'b0;
  logic        lsu_we_i = 1'b0;
  logic [2:0]  lsu_size_i = '0;
  logic [31:0] lsu_addr_i = '0;
  logic [31:0] lsu_data_i = '0;
  logic [31:0] lsu_data_o;
  logic        lsu_stall_req_o;
  logic        lsu_misaligned_o;
  logic        data_req_o;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_addr_o;
  logic [31:0] data_wdata_o;
  logic        data_gnt_i = 1'b0;
  logic        data_rvalid_i = 1'b0;
  logic [31:0] data_rdata_i = '0;

  int          vec_cnt = 0;
  int          err_cnt = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_load = '0;

  miriscv_lsu dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_size_i(lsu_size_i),
    .lsu_addr_i(lsu_addr_i), .lsu_data_i(lsu_data_i), .lsu_data_o(lsu_data_o),
    .lsu_stall_req_o(lsu_stall_req_o), .lsu_misaligned_o(lsu_misaligned_o),
    .data_req_o(data_req_o), .data_we_o(data_we_o), .data_be_o(data_be_o),
    .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o),
    .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i)
  );

  // Clock / watchdog
  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vec_cnt);
    $fatal(1, "watchdog");
  end

  // Reference models
  function automatic logic [3:0] model_be(input logic [2:0] size, input logic [31:0] addr);
    case (size)
      3'b000, 3'b100: model_be = 4'b0001 << addr[1:0];
      3'b001, 3'b101: model_be = addr[1] ? 4'b1100 : 4'b0011;
      default:        model_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] size, input logic [31:0] d);
    case (size)
      3'b000, 3'b100: model_wdata = {d[7:0], d[7:0], d[7:0], d[7:0]};
      3'b001, 3'b101: model_wdata = {d[15:0], d[15:0]};
      default:        model_wdata = d;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] size, input logic [31:0] addr,
                                             input logic [31:0] rdata);
    logic [31:0] sh;
    case (size)
      3'b000: begin sh = rdata >> (8 * addr[1:0]); model_load = {{24{sh[7]}}, sh[7:0]}; end
      3'b100: begin sh = rdata >> (8 * addr[1:0]); model_load = {24'h0, sh[7:0]}; end
      3'b001: begin sh = rdata >> (16 * addr[1]);  model_load = {{16{sh[15]}}, sh[15:0]}; end
      3'b101: begin sh = rdata >> (16 * addr[1]);  model_load = {16'h0, sh[15:0]}; end
      default: model_load = rdata;
    endcase
  endfunction

  task automatic apply_reset();
    @(negedge clk_i);
    rstn_i = 1'b0; lsu_req_i = 1'b0; data_gnt_i = 1'b0; data_rvalid_i = 1'b0;
    @(negedge clk_i);
    rstn_i = 1'b1;
    last_load = '0;
  endtask

  // Driver: one access with a responder granting after gnt_dly REQ cycles and returning
  // rvalid rv_dly cycles into WAIT; stray=1 adds rvalid in REQ and gnt in WAIT.
  task automatic do_access(input string name, input logic we, input logic [2:0] size,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input int gnt_dly, input int rv_dly, input logic [31:0] rdata,
                           input logic stray, input logic [3:0] exp_be,
                           input logic [31:0] exp_wdata, input logic [31:0] exp_waddr,
                           input logic [31:0] exp_data);
    int stall_cnt, req_cnt, wait_cnt, exp_stall;
    bit granted, done;
    logic [31:0] exp_ld;
    stall_cnt = 0; req_cnt = 0; wait_cnt = 0; granted = 0; done = 0;
    exp_stall = we ? gnt_dly + 2 : gnt_dly + rv_dly + 3;
    exp_q.push_back(exp_data);
    @(negedge clk_i);
    lsu_req_i = 1'b1; lsu_we_i = we; lsu_size_i = size; lsu_addr_i = addr; lsu_data_i = wdata;
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      if (cyc > 0) @(negedge clk_i);
      data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = $urandom;
      #1;
      if (!lsu_stall_req_o) begin
        done = 1;
        exp_ld = exp_q.pop_front();
        vec_cnt++;
        if (stall_cnt !== exp_stall) begin
          err_cnt++; $display("FAIL %s stall_cycles: got %0d expected %0d", name, stall_cnt, exp_stall);
        end
        vec_cnt++;
        if (req_cnt !== gnt_dly + 1) begin
          err_cnt++; $display("FAIL %s req_cycles: got %0d expected %0d", name, req_cnt, gnt_dly + 1);
        end
        vec_cnt++;
        if (lsu_data_o !== exp_ld) begin
          err_cnt++; $display("FAIL %s lsu_data_o: got %08h expected %08h", name, lsu_data_o, exp_ld);
        end
        vec_cnt++;
        if (data_req_o !== 1'b0 || lsu_misaligned_o !== 1'b0) begin
          err_cnt++; $display("FAIL %s done_flags: req=%b mis=%b expected 0 0", name, data_req_o, lsu_misaligned_o);
        end
        lsu_req_i = 1'b0;
      end else begin
        stall_cnt++;
        if (data_req_o) begin
          if (req_cnt == 0) begin
            vec_cnt++;
            if (data_addr_o !== exp_waddr || data_be_o !== exp_be ||
                data_wdata_o !== exp_wdata || data_we_o !== we) begin
              err_cnt++;
              $display("FAIL %s mem_req: addr=%08h be=%b wdata=%08h we=%b expected addr=%08h be=%b wdata=%08h we=%b",
                       name, data_addr_o, data_be_o, data_wdata_o, data_we_o, exp_waddr, exp_be, exp_wdata, we);
            end
          end
          req_cnt++;
          if (req_cnt == gnt_dly + 1) begin
            data_gnt_i = 1'b1; granted = 1;
          end else if (stray) begin
            data_rvalid_i = 1'b1; data_rdata_i = 32'hBAD0_BAD0;
          end
        end else if (granted) begin
          if (wait_cnt == rv_dly) begin
            data_rvalid_i = 1'b1; data_rdata_i = rdata;
          end else if (stray) begin
            data_gnt_i = 1'b1;
          end
          wait_cnt++;
        end
      end
    end
    if (!done) begin
      vec_cnt++; err_cnt++;
      $display("FAIL %s timeout: access did not complete in 60 cycles", name);
      void'(exp_q.pop_front());
      apply_reset();
    end
    if (!we) last_load = exp_data;
  endtask

  task automatic test_reset();
    rstn_i = 1'b0; lsu_req_i = 1'b0;
    @(negedge clk_i); @(negedge clk_i); #1;
    vec_cnt++;
    if (lsu_data_o !== 32'h0 || data_addr_o !== 32'h0 || data_wdata_o !== 32'h0) begin
      err_cnt++; $display("FAIL reset_data: data=%08h addr=%08h wdata=%08h expected all 0", lsu_data_o, data_addr_o, data_wdata_o);
    end
    vec_cnt++;
    if (data_req_o !== 1'b0 || data_we_o !== 1'b0 || data_be_o !== 4'h0 ||
        lsu_stall_req_o !== 1'b0 || lsu_misaligned_o !== 1'b0) begin
      err_cnt++; $display("FAIL reset_ctrl: req=%b we=%b be=%b stall=%b mis=%b expected 0",
                          data_req_o, data_we_o, data_be_o, lsu_stall_req_o, lsu_misaligned_o);
    end
    rstn_i = 1'b1;
  endtask

  task automatic test_store_word();
    do_access("store_word", 1'b1, 3'b010, 32'h104, 32'hDEADBEEF, 0, 0, 32'h0, 1'b0,
              4'b1111, 32'hDEADBEEF, 32'h104, last_load);
  endtask

  task automatic test_load_byte();
    do_access("load_byte_signed", 1'b0, 3'b000, 32'h203, 32'h0, 0, 0, 32'h80123456, 1'b0,
              4'b1000, 32'h0, 32'h200, 32'hFFFFFF80);
    do_access("load_byte_unsigned", 1'b0, 3'b100, 32'h203, 32'h0, 0, 0, 32'h80123456, 1'b0,
              4'b1000, 32'h0, 32'h200, 32'h00000080);
  endtask

  task automatic test_store_half();
    do_access("store_half", 1'b1, 3'b001, 32'h12, 32'h0000ABCD, 0, 0, 32'h0, 1'b0,
              4'b1100, 32'hABCDABCD, 32'h10, last_load);
  endtask

  task automatic test_delayed_grant();
    do_access("delayed_grant", 1'b0, 3'b010, 32'h300, 32'h0, 3, 2, 32'hCAFEF00D, 1'b1,
              4'b1111, 32'h0, 32'h300, 32'hCAFEF00D);
    do_access("load_half_signed", 1'b0, 3'b001, 32'h302, 32'h0, 1, 1, 32'h9ABC1234, 1'b1,
              4'b1100, 32'h0, 32'h300, 32'hFFFF9ABC);
  endtask

  task automatic test_misaligned();
`ifdef LSU_MISALIGN_EXC_EN
    @(negedge clk_i);
    lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_size_i = 3'b010; lsu_addr_i = 32'h102;
    #1;
    vec_cnt++;
    if (data_req_o !== 1'b0 || lsu_misaligned_o !== 1'b0 || lsu_stall_req_o !== 1'b1) begin
      err_cnt++; $display("FAIL misaligned_idle: req=%b mis=%b stall=%b expected 0 0 1", data_req_o, lsu_misaligned_o, lsu_stall_req_o);
    end
    @(negedge clk_i); #1;
    vec_cnt++;
    if (data_req_o !== 1'b0 || lsu_misaligned_o !== 1'b1 || lsu_stall_req_o !== 1'b0 || lsu_data_o !== last_load) begin
      err_cnt++; $display("FAIL misaligned_done: req=%b mis=%b stall=%b data=%08h expected 0 1 0 %08h",
                          data_req_o, lsu_misaligned_o, lsu_stall_req_o, lsu_data_o, last_load);
    end
    lsu_req_i = 1'b0;
    @(negedge clk_i); #1;
    vec_cnt++;
    if (lsu_misaligned_o !== 1'b0 || data_req_o !== 1'b0) begin
      err_cnt++; $display("FAIL misaligned_pulse: mis=%b req=%b expected 0 0", lsu_misaligned_o, data_req_o);
    end
`else
    do_access("misaligned_word", 1'b0, 3'b010, 32'h102, 32'h0, 0, 0, 32'h11223344, 1'b0,
              4'b1111, 32'h0, 32'h100, 32'h11223344);
    do_access("misaligned_half", 1'b1, 3'b101, 32'h13, 32'h00005678, 0, 0, 32'h0, 1'b0,
              4'b1100, 32'h56785678, 32'h10, last_load);
`endif
  endtask

  task automatic test_random();
    logic [2:0]  size;
    logic [31:0] addr, wd, rd, exp_d;
    logic        we;
    for (int i = 0; i < 24; i++) begin
      size = 3'($urandom_range(0, 7));
      addr = $urandom;
      we   = 1'($urandom_range(0, 1));
      wd   = $urandom;
      rd   = $urandom;
`ifdef LSU_MISALIGN_EXC_EN
      if (size[1:0] == 2'b01) addr[0] = 1'b0;
      else if (size[1:0] != 2'b00) addr[1:0] = 2'b00;
`endif
      exp_d = we ? last_load : model_load(size, addr, rd);
      do_access("random", we, size, addr, wd, $urandom_range(0, 2), $urandom_range(0, 2), rd,
                1'($urandom_range(0, 1)), model_be(size, addr), model_wdata(size, wd),
                {addr[31:2], 2'b00}, exp_d);
    end
  endtask

  task automatic test_reset_in_wait();
    @(negedge clk_i);
    lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_size_i = 3'b010; lsu_addr_i = 32'h400;
    @(negedge clk_i); #1;
    vec_cnt++;
    if (data_req_o !== 1'b1) begin
      err_cnt++; $display("FAIL rst_wait_req: data_req_o=%b expected 1", data_req_o);
    end
    data_gnt_i = 1'b1;
    @(negedge clk_i);
    data_gnt_i = 1'b0;
    #1;
    vec_cnt++;
    if (data_req_o !== 1'b0 || lsu_stall_req_o !== 1'b1) begin
      err_cnt++; $display("FAIL rst_wait_state: req=%b stall=%b expected 0 1", data_req_o, lsu_stall_req_o);
    end
    rstn_i = 1'b0;
    @(negedge clk_i);
    rstn_i = 1'b1; lsu_req_i = 1'b0; data_rvalid_i = 1'b1; data_rdata_i = 32'h12345678;
    #1;
    vec_cnt++;
    if (lsu_data_o !== 32'h0 || data_req_o !== 1'b0 || data_be_o !== 4'h0 || data_addr_o !== 32'h0) begin
      err_cnt++; $display("FAIL rst_wait_cleared: data=%08h req=%b be=%b addr=%08h expected 0",
                          lsu_data_o, data_req_o, data_be_o, data_addr_o);
    end
    @(negedge clk_i);
    data_rvalid_i = 1'b0;
    #1;
    vec_cnt++;
    if (lsu_data_o !== 32'h0 || lsu_stall_req_o !== 1'b0 || data_req_o !== 1'b0) begin
      err_cnt++; $display("FAIL rst_late_rvalid: data=%08h stall=%b req=%b expected 0 0 0",
                          lsu_data_o, lsu_stall_req_o, data_req_o);
    end
    last_load = '0;
    do_access("after_reset_store", 1'b1, 3'b000, 32'h501, 32'h000000A5, 0, 0, 32'h0, 1'b0,
              4'b0010, 32'hA5A5A5A5, 32'h500, 32'h0);
  endtask

  task automatic test_back_to_back();
    do_access("b2b_load", 1'b0, 3'b101, 32'h602, 32'h0, 0, 0, 32'hFEDC0000, 1'b0,
              4'b1100, 32'h0, 32'h600, 32'h0000FEDC);
    do_access("b2b_store", 1'b1, 3'b100, 32'h700, 32'h000000EE, 0, 0, 32'h0, 1'b0,
              4'b0001, 32'hEEEEEEEE, 32'h700, 32'h0000FEDC);
    do_access("b2b_load_sized011", 1'b0, 3'b011, 32'h800, 32'h0, 0, 0, 32'h87654321, 1'b0,
              4'b1111, 32'h0, 32'h800, 32'h87654321);
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_load_byte();
    test_store_half();
    test_delayed_grant();
    test_reset_in_wait();
    test_back_to_back();
    test_misaligned();
    test_random();
    @(negedge clk_i);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
